// File: rtl/reg_file_pkg.sv
// Shared defaults and request type for the register-bank write controller.
package reg_file_pkg;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DEPTH  = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data;
  } wr_req_t;

endpackage

// File: rtl/reg_wr_ctrl_if.sv
// Write-request, bank-issue and forwarding signals of reg_wr_ctrl.
interface reg_wr_ctrl_if
  import reg_file_pkg::*;
#(
  parameter int unsigned WIDTH = reg_file_pkg::WIDTH,
  parameter int unsigned DEPTH = reg_file_pkg::DEPTH
) ();

  logic                       wr_valid;
  logic                       wr_ready;
  logic [ADDR_W-1:0]          wr_addr;
  logic [WIDTH-1:0]           wr_data;
  logic                       hold;
  logic                       bank_en;
  logic [WIDTH-1:0]           bank_sel;
  logic [WIDTH-1:0]           bank_data;
  logic [ADDR_W-1:0]          rd_addr;
  logic                       fwd_hit;
  logic [WIDTH-1:0]           fwd_data;
  logic [$clog2(DEPTH):0]     count;

  modport master (
    output wr_valid, wr_addr, wr_data, hold, rd_addr,
    input  wr_ready, bank_en, bank_sel, bank_data, fwd_hit, fwd_data, count
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, hold, rd_addr,
    output wr_ready, bank_en, bank_sel, bank_data, fwd_hit, fwd_data, count
  );

endinterface

// File: rtl/reg_wr_fifo.sv
// Write-queue storage and pointers; all entries are exposed for forwarding lookup.
module reg_wr_fifo
  import reg_file_pkg::*;
#(
  parameter int unsigned WIDTH = reg_file_pkg::WIDTH,
  parameter int unsigned DEPTH = reg_file_pkg::DEPTH,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [ADDR_W-1:0]            push_addr_i,
  input  logic [WIDTH-1:0]             push_data_i,
  output logic [PtrW-1:0]              rd_ptr_o,
  output logic [CntW-1:0]              count_o,
  output logic [DEPTH-1:0][ADDR_W-1:0] ent_addr_o,
  output logic [DEPTH-1:0][WIDTH-1:0]  ent_data_o
);

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
  logic [DEPTH-1:0][WIDTH-1:0]  data_q;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PtrW'(push_i);
    rd_ptr_d = rd_ptr_q + PtrW'(pop_i);
    count_d  = count_q + CntW'(push_i) - CntW'(pop_i);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload is left unreset; consumers gate it with count.
  always_ff @(posedge clk) begin
    if (push_i) begin
      addr_q[wr_ptr_q] <= push_addr_i;
      data_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign rd_ptr_o   = rd_ptr_q;
  assign count_o    = count_q;
  assign ent_addr_o = addr_q;
  assign ent_data_o = data_q;

endmodule

// File: rtl/reg_wr_ctrl.sv
// Queued register-bank write controller with one-hot issue and read forwarding.
module reg_wr_ctrl
  import reg_file_pkg::*;
#(
  parameter int unsigned WIDTH = reg_file_pkg::WIDTH,
  parameter int unsigned DEPTH = reg_file_pkg::DEPTH
) (
  input logic         clk,
  input logic         rst,
  reg_wr_ctrl_if.slave bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0]              rd_ptr;
  logic [CntW-1:0]              count;
  logic [DEPTH-1:0][ADDR_W-1:0] ent_addr;
  logic [DEPTH-1:0][WIDTH-1:0]  ent_data;

  logic              not_empty;
  logic              wr_ready;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] head_addr;
  logic [WIDTH-1:0]  head_data;

  assign not_empty = (count != '0);
  assign wr_ready  = (count != CntW'(DEPTH));
  assign push      = bus.wr_valid && wr_ready;
  assign pop       = not_empty && !bus.hold;
  assign head_addr = ent_addr[rd_ptr];
  assign head_data = ent_data[rd_ptr];

  reg_wr_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .pop_i       (pop),
    .push_addr_i (bus.wr_addr),
    .push_data_i (bus.wr_data),
    .rd_ptr_o    (rd_ptr),
    .count_o     (count),
    .ent_addr_o  (ent_addr),
    .ent_data_o  (ent_data)
  );

  // Addresses beyond the bank width select nothing.
  always_comb begin
    bus.bank_sel = '0;
    if (pop && (32'(head_addr) < WIDTH)) begin
      bus.bank_sel[head_addr] = 1'b1;
    end
  end

  // Scan oldest to youngest so the last match is the youngest entry.
  logic [PtrW-1:0] idx;
  always_comb begin
    idx          = '0;
    bus.fwd_hit  = 1'b0;
    bus.fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PtrW'(i);
      if ((CntW'(i) < count) && (ent_addr[idx] == bus.rd_addr)) begin
        bus.fwd_hit  = 1'b1;
        bus.fwd_data = ent_data[idx];
      end
    end
  end

  assign bus.wr_ready  = wr_ready;
  assign bus.bank_en   = pop;
  assign bus.bank_data = not_empty ? head_data : '0;
  assign bus.count     = count;

endmodule

// File: tb/tb_reg_wr_ctrl.sv
// Self-checking bench for reg_wr_ctrl: vector table, corner sequences, random vs queue model.
module tb_reg_wr_ctrl;
  import reg_file_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  reg_wr_ctrl_if #(.WIDTH(32), .DEPTH(4)) bus ();

  reg_wr_ctrl #(.WIDTH(32), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int fails  = 0;
  wr_req_t q[$];

  typedef struct {
    logic        v;
    logic [4:0]  a;
    logic [31:0] d;
    logic        h;
    logic [4:0]  r;
    logic        rdy;
    logic        en;
    logic [31:0] sel;
    logic [31:0] bdata;
    logic [2:0]  cnt;
    logic        hit;
    logic [31:0] fwd;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_outs(input logic rdy, input logic en, input logic [31:0] sel,
                          input logic [31:0] bdata, input logic [2:0] cnt,
                          input logic hit, input logic [31:0] fwd);
    chk("wr_ready", 32'(bus.wr_ready), 32'(rdy));
    chk("bank_en", 32'(bus.bank_en), 32'(en));
    chk("bank_sel", bus.bank_sel, sel);
    chk("bank_data", bus.bank_data, bdata);
    chk("count", 32'(bus.count), 32'(cnt));
    chk("fwd_hit", 32'(bus.fwd_hit), 32'(hit));
    chk("fwd_data", bus.fwd_data, fwd);
  endtask

  // Expected outputs straight from the queue contents and current inputs.
  task automatic chk_model();
    logic        en, hit;
    logic [31:0] sel, bdata, fwd;
    en    = (q.size() != 0) && !bus.hold;
    sel   = en ? (32'd1 << q[0].addr) : 32'd0;
    bdata = (q.size() != 0) ? q[0].data : 32'd0;
    hit   = 1'b0;
    fwd   = 32'd0;
    foreach (q[i]) begin
      if (q[i].addr == bus.rd_addr) begin
        hit = 1'b1;
        fwd = q[i].data;
      end
    end
    chk_outs(q.size() != 4, en, sel, bdata, 3'(q.size()), hit, fwd);
  endtask

  task automatic model_edge(input logic v, input logic [4:0] a, input logic [31:0] d,
                            input logic h);
    logic rdy;
    rdy = (q.size() != 4);
    if ((q.size() != 0) && !h) void'(q.pop_front());
    if (v && rdy) q.push_back('{addr: a, data: d});
  endtask

  task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d,
                       input logic h, input logic [4:0] r);
    bus.wr_valid = v;
    bus.wr_addr  = a;
    bus.wr_data  = d;
    bus.hold     = h;
    bus.rd_addr  = r;
  endtask

  task automatic step(input logic v, input logic [4:0] a, input logic [31:0] d,
                      input logic h, input logic [4:0] r);
    drive(v, a, d, h, r);
    @(negedge clk);
    chk_model();
    @(posedge clk);
    model_edge(v, a, d, h);
    #1;
  endtask

  initial begin
    logic        pv, ph, held, acc;
    logic [4:0]  pa, pr;
    logic [31:0] pd;

    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    #12;
    chk_outs(1'b1, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // v a d h r | rdy en sel bdata cnt hit fwd
    tbl[0] = '{1, 3, 32'hDEADBEEF, 0, 3, 1, 0, 32'h0, 32'h0, 0, 0, 32'h0};
    tbl[1] = '{0, 0, 32'h0, 0, 3, 1, 1, 32'h8, 32'hDEADBEEF, 1, 1, 32'hDEADBEEF};
    tbl[2] = '{0, 0, 32'h0, 0, 3, 1, 0, 32'h0, 32'h0, 0, 0, 32'h0};
    tbl[3] = '{1, 7, 32'h11, 1, 7, 1, 0, 32'h0, 32'h0, 0, 0, 32'h0};
    tbl[4] = '{1, 7, 32'h22, 1, 7, 1, 0, 32'h0, 32'h11, 1, 1, 32'h11};
    tbl[5] = '{0, 0, 32'h0, 1, 7, 1, 0, 32'h0, 32'h11, 2, 1, 32'h22};
    tbl[6] = '{0, 0, 32'h0, 1, 8, 1, 0, 32'h0, 32'h11, 2, 0, 32'h0};
    tbl[7] = '{0, 0, 32'h0, 0, 7, 1, 1, 32'h80, 32'h11, 2, 1, 32'h22};
    tbl[8] = '{0, 0, 32'h0, 0, 7, 1, 1, 32'h80, 32'h22, 1, 1, 32'h22};
    tbl[9] = '{0, 0, 32'h0, 0, 7, 1, 0, 32'h0, 32'h0, 0, 0, 32'h0};
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].h, tbl[i].r);
      @(negedge clk);
      chk_outs(tbl[i].rdy, tbl[i].en, tbl[i].sel, tbl[i].bdata, tbl[i].cnt, tbl[i].hit,
               tbl[i].fwd);
      @(posedge clk);
      model_edge(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].h);
      #1;
    end

    // Fill under hold, hold a 5th request while full, then drain.
    for (int i = 1; i <= 4; i++) step(1'b1, 5'(i), 32'(i * 16), 1'b1, 5'd2);
    step(1'b1, 5'd5, 32'h55, 1'b1, 5'd4);
    chk("full_count", 32'(bus.count), 32'd4);
    step(1'b1, 5'd5, 32'h55, 1'b0, 5'd5);
    step(1'b1, 5'd5, 32'h55, 1'b0, 5'd5);
    for (int i = 0; i < 4; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd5);

    // Streaming: one issue per cycle, pointers wrap.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 5'(i), 32'hA000 + 32'(i), 1'b0, 5'(i));
      chk("stream_count_le1", 32'(bus.count <= 1), 32'd1);
    end
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);

    // Asynchronous reset with three entries pending.
    for (int i = 0; i < 3; i++) step(1'b1, 5'(10 + i), 32'hC0 + 32'(i), 1'b1, 5'd11);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd11);
    #2;
    rst = 1'b0;
    #1;
    chk_outs(1'b1, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 32'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd11);

    // Random traffic; a refused request is held by the source.
    held = 1'b0;
    pv = 1'b0; pa = '0; pd = '0;
    for (int n = 0; n < 400; n++) begin
      if (!held) begin
        pv = ($urandom_range(0, 2) != 0);
        pa = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
        pd = $urandom;
      end
      ph   = ($urandom_range(0, 3) == 0);
      pr   = 5'($urandom_range(0, 9));
      acc  = pv && (q.size() != 4);
      step(pv, pa, pd, ph, pr);
      held = pv && !acc;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/reg_wr_ctrl.md
REG_WR_CTRL -- requirements
Module: reg_wr_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, data width and register count.
REQ-002 The block SHALL have parameter DEPTH, default 4, write-queue entries (power of two, >=2).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-005 The block SHALL have port wr_valid, input, 1, write request present.
REQ-006 The block SHALL have port wr_ready, output, 1, queue can accept a request.
REQ-007 The block SHALL have port wr_addr, input, 5, destination register index.
REQ-008 The block SHALL have port wr_data, input, WIDTH, write data.
REQ-009 The block SHALL have port hold, input, 1, register bank stall; suppresses issue.
REQ-010 The block SHALL have port bank_en, output, 1, global write enable to bank.
REQ-011 The block SHALL have port bank_sel, output, WIDTH, one-hot per-register enable.
REQ-012 The block SHALL have port bank_data, output, WIDTH, data to bank.
REQ-013 The block SHALL have port rd_addr, input, 5, read index for forwarding lookup.
REQ-014 The block SHALL have port fwd_hit, output, 1, rd_addr matches a queued write.
REQ-015 The block SHALL have port fwd_data, output, WIDTH, data of youngest matching entry.
REQ-016 The block SHALL have port count, output, $clog2(DEPTH)+1, queued entries.

Function
REQ-017 The block SHALL accept (push) a request on a rising edge where wr_valid and wr_ready are both 1.
REQ-018 wr_ready SHALL equal (count != DEPTH); no push when full, even if a pop occurs that cycle.
REQ-019 wr_valid with wr_ready=0 SHALL be held by the source; the block SHALL NOT drop or duplicate it.
REQ-020 bank_en SHALL be (count != 0) && !hold, combinational from registered state.
REQ-021 bank_sel SHALL be one-hot decode of the head entry address when bank_en=1, all zero otherwise.
REQ-022 bank_data SHALL be the head entry data when count!=0, zero when empty.
REQ-023 A pop SHALL occur on every rising edge where bank_en=1 (bank always consumes).
REQ-024 Latency: request pushed at edge N into empty queue SHALL drive bank_en=1 in the cycle after edge N (bank writes at edge N+1).
REQ-025 Simultaneous push and pop SHALL leave count unchanged; push-only +1; pop-only -1.
REQ-026 Read/write pointers SHALL wrap modulo DEPTH.
REQ-027 Queue order SHALL be strict FIFO; two writes to the same address SHALL both issue in order.
REQ-028 fwd_hit SHALL be 1 iff any occupied entry has address == rd_addr, combinational.
REQ-029 fwd_data SHALL be the data of the youngest matching occupied entry, zero if no hit.
REQ-030 An entry popping in the current cycle SHALL still count for fwd_hit in that cycle.
REQ-031 The request being pushed in the current cycle SHALL NOT count for forwarding.
REQ-032 hold SHALL NOT affect wr_ready or pushes.

Reset
REQ-033 On rst=0 the block SHALL asynchronously clear pointers and count; wr_ready=1, bank_en=0, bank_sel=0, bank_data=0, fwd_hit=0, fwd_data=0.
REQ-034 Reset mid-operation SHALL discard all queued writes; none SHALL issue after release.
REQ-035 Entry data storage need not be reset; outputs SHALL be gated by occupancy.

Structure
REQ-036 Package reg_file_pkg SHALL hold WIDTH=32, ADDR_W=5, DEPTH=4 defaults and the wr_req_t struct {addr, data}.
REQ-037 Storage and pointers SHALL be one sub-module, reg_wr_fifo; decode and forwarding stay in reg_wr_ctrl.

Verification
REQ-038 Reset, then push addr=3 data=0xDEADBEEF, hold=0 -> next cycle bank_en=1, bank_sel=0x00000008, bank_data=0xDEADBEEF; count returns to 0.
REQ-039 hold=1, push 4 requests (addr 1,2,3,4) -> count=4, wr_ready=0, bank_en=0; 5th wr_valid not accepted; release hold -> sel 0x2,0x4,0x8,0x10 in 4 consecutive cycles.
REQ-040 hold=1, queue addr=7 data=0x11 then addr=7 data=0x22, rd_addr=7 -> fwd_hit=1, fwd_data=0x22; rd_addr=8 -> fwd_hit=0, fwd_data=0.
REQ-041 Continuous wr_valid with hold=0 for 10 cycles, addresses 0..9 -> count stays <=1, one bank write per cycle in order, pointer wrap exercised.
REQ-042 hold=1, 3 entries queued, assert rst=0 mid-cycle -> outputs clear immediately; after release, bank_en stays 0 with hold=0.
REQ-043 Full queue, hold=0, wr_valid=1 -> wr_ready=0 that cycle, push accepted the cycle after count drops to 3.
